sseg_mux_ctrl_core: RTL and testbench
=====================================

// Module: sseg_mux_ctrl_core
// PURPOSE
// - MMIO slot core that time-multiplexes N_DIGITS seven-segment digits. It is the parametrised
//   successor of the fixed 8-digit LED mux core.
// - Adds digit count, per-digit blanking, per-digit blink, 16-level PWM brightness and register readback.
// - Sits in the MMIO subsystem behind the standard slot interface; drives the board sseg/an pins.
// PARAMETERS
// - N_DIGITS      8   number of digits, legal range 1..16
// - SLOT_BITS     11  width of the per-digit slot counter; slot length = 2**SLOT_BITS clk cycles, legal >= 4
// - BLINK_FRAMES  32  number of full scan frames per blink half-period, legal >= 1
// PORTS
// - clk      in   1         system clock
// - reset    in   1         synchronous, active-high reset
// - cs       in   1         slot select
// - read     in   1         read strobe (unused internally; rd_data is valid whenever cs is high)
// - write    in   1         write strobe
// - addr     in   5         word address
// - wr_data  in   32        write data
// - rd_data  out  32        read data
// - sseg     out  8         segment pattern, active-low, bit7 = dp
// - an       out  N_DIGITS  digit enables, active-low, at most one bit low
// BEHAVIOUR
// - One clock, clk. reset is synchronous, active-high, sampled on posedge clk.
// - Register map; a write occurs when cs & write, keyed by addr:
//   * 0..3  DATA[k]  byte j is the raw active-low pattern of digit 4k+j.
//           Bytes for digits >= N_DIGITS are not stored and read 0.
//   * 4     MASK     [15:0] blank mask; [31:16] blink mask. Bit i applies to digit i.
//           Bits >= N_DIGITS are not stored and read 0.
//   * 5     BRIGHT   [3:0] brightness B, 0..15; other bits read 0.
//   * 6     STATUS   read-only: [3:0] current digit index; [8] blink phase; [31:16] frame count mod 2**16.
//           Writes to STATUS are ignored.
//   * 7..31 reads return 0; writes are ignored.
// - rd_data is combinational from addr and is valid whenever cs is high.
// - Reset state:
//   * DATA = 0, MASK = 0, BRIGHT = 15.
//   * slot counter = 0, digit index = 0, frame count = 0, blink counter = 0, blink phase = 0.
//   * an = all ones, sseg = 8'hFF.
// - Scan:
//   * The slot counter increments every cycle and wraps after 2**SLOT_BITS-1.
//   * On wrap, the digit index increments, wrapping from N_DIGITS-1 to 0.
//   * When the digit index wraps, the frame count increments.
//   * When a frame ends, the blink counter increments. On the frame end that brings it to
//     BLINK_FRAMES, blink phase toggles and the blink counter clears.
// - on = ~blank[d] & ~(blink[d] & phase) & (slot_cnt[SLOT_BITS-1 -: 4] <= B), where d = digit index.
// - Outputs are registered, one cycle after the counter state:
//   * on = 1: an = ~(1 << d), sseg = DATA byte d.
//   * on = 0: an = all ones, sseg = 8'hFF.
// - B = 15 gives 100% duty; B = 0 gives 1/16 duty. Full off is done only through the blank mask.
// - Write latency: a register written at edge k is reflected on sseg/an at edge k+1.
//   This applies mid-slot too; brightness, mask and data changes are not deferred to a slot boundary.
// - A write never resets or perturbs the scan counters.
// - N_DIGITS = 1: the digit index stays 0 and every slot wrap is a frame end.
// - Reset asserted mid-slot or mid-blink returns every register to its reset state on the next edge.
// TESTING
// Bench configuration: N_DIGITS=4, SLOT_BITS=6, BLINK_FRAMES=2.
// - Reset, then idle 300 cycles -> an=4'b1111 and sseg=8'hFF throughout.
//   STATUS then reads index 0, frame count 0 and phase 0 during reset, then advances.
// - Write DATA0=32'hC0F9A4B0, B=15 -> each digit is driven for 64 consecutive cycles.
//   Order: an=1110/sseg=B0, 1101/A4, 1011/F9, 0111/C0, then repeat.
//   Frame count +1 every 256 cycles.
// - Set B=3 -> within each 64-cycle slot, an is low for exactly 16 cycles (slot_cnt 0..15) and high for 48.
// - Write MASK=32'h0002_0001 -> digit0 is never lit. Digit1 is lit during phase 0 and dark during phase 1.
//   Phase toggles every 512 cycles.
// - Readback: DATA1 and bytes 0..3 of MASK hold only bits for digits < 4, so DATA1 reads 0.
//   MASK=32'hFFFF_FFFF reads 32'h000F_000F. Writing STATUS or addr 9 leaves all state unchanged.
// - Assert reset mid-slot on digit 2 -> next edge gives an=1111, sseg=FF, index 0, B=15 and all DATA cleared.

Source files
------------

// File: rtl/sseg_mux_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module      : sseg_mux_ctrl_core
// Description : MMIO slot core that time-multiplexes N_DIGITS seven-segment
//               digits. It provides per-digit raw patterns, a blank mask, a
//               blink mask, 16-level PWM brightness and register readback.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               cs, read, write    - slot select and strobes
//               addr, wr_data      - word address and write data
//               rd_data            - combinational readback, valid when cs=1
//               sseg               - active-low segments, bit7 = dp
//               an                 - active-low digit enables
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_mux_ctrl_core #(
    parameter int N_DIGITS     = 8,
    parameter int SLOT_BITS    = 11,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                read,
    input  logic                write,
    input  logic [4:0]          addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data,
    output logic [7:0]          sseg,
    output logic [N_DIGITS-1:0] an
);

    localparam int               BCNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]       LAST_DIGIT  = 4'(N_DIGITS - 1);
    localparam logic [4:0]       ADDR_MASK   = 5'd4;
    localparam logic [4:0]       ADDR_BRIGHT = 5'd5;
    localparam logic [4:0]       ADDR_STATUS = 5'd6;

    // Register file
    logic [7:0]          digit_data [N_DIGITS];
    logic [N_DIGITS-1:0] blank_mask;
    logic [N_DIGITS-1:0] blink_mask;
    logic [3:0]          bright;

    // Scan state
    logic [SLOT_BITS-1:0] slot_cnt;
    logic [3:0]           digit_idx;
    logic [15:0]          frame_cnt;
    logic [BCNT_W-1:0]    blink_cnt;
    logic                 blink_phase;

    logic                wr_en;
    logic                slot_wrap;
    logic                frame_end;
    logic [7:0]          cur_data;
    logic                cur_blank;
    logic                cur_blink;
    logic                lit;
    logic [N_DIGITS-1:0] an_next;
    logic [7:0]          sseg_next;

    // read strobe carries no side effects; rd_data is decoded from addr alone
    logic unused_inputs;
    assign unused_inputs = &{1'b0, read, wr_data};

    assign wr_en     = cs & write;
    assign slot_wrap = &slot_cnt;
    assign frame_end = slot_wrap && (digit_idx == LAST_DIGIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                digit_data[i] <= 8'h00;
            end
            blank_mask <= '0;
            blink_mask <= '0;
            bright     <= 4'hF;
        end else if (wr_en) begin
            // Digit i lives in byte i%4 of DATA word i/4; bytes beyond the
            // configured digit count simply have no storage behind them.
            for (int i = 0; i < N_DIGITS; i++) begin
                if (addr == 5'(i / 4)) begin
                    digit_data[i] <= wr_data[(i % 4) * 8 +: 8];
                end
            end
            if (addr == ADDR_MASK) begin
                blank_mask <= wr_data[N_DIGITS-1:0];
                blink_mask <= wr_data[16 +: N_DIGITS];
            end
            if (addr == ADDR_BRIGHT) begin
                bright <= wr_data[3:0];
            end
        end
    end

    // Scan counters are never touched by register writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= 4'd0;
            frame_cnt   <= 16'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + SLOT_BITS'(1);
            if (slot_wrap) begin
                digit_idx <= (digit_idx == LAST_DIGIT) ? 4'd0 : digit_idx + 4'd1;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (blink_cnt == BCNT_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cur_data  = 8'hFF;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == 4'(i)) begin
                cur_data  = digit_data[i];
                cur_blank = blank_mask[i];
                cur_blink = blink_mask[i];
            end
        end
        // The top four slot-counter bits divide each slot into 16 PWM steps;
        // the digit is lit for steps 0..B, so B=0 still gives 1/16 duty.
        lit = ~cur_blank & ~(cur_blink & blink_phase)
            & (slot_cnt[SLOT_BITS-1 -: 4] <= bright);
        for (int i = 0; i < N_DIGITS; i++) begin
            an_next[i] = ~(lit && (digit_idx == 4'(i)));
        end
        sseg_next = lit ? cur_data : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an   <= '1;
            sseg <= 8'hFF;
        end else begin
            an   <= an_next;
            sseg <= sseg_next;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (addr == 5'(i / 4)) begin
                rd_data[(i % 4) * 8 +: 8] = digit_data[i];
            end
        end
        case (addr)
            ADDR_MASK: begin
                rd_data[N_DIGITS-1:0]   = blank_mask;
                rd_data[16 +: N_DIGITS] = blink_mask;
            end
            ADDR_BRIGHT: rd_data[3:0] = bright;
            ADDR_STATUS: rd_data = {frame_cnt, 7'd0, blink_phase, 4'd0, digit_idx};
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_mux_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_mux_ctrl_core
// Description : Self-checking bench for sseg_mux_ctrl_core (4 digits,
//               64-cycle slots, 2-frame blink half-period). Expected outputs
//               come from a cycle-count model of the scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_mux_ctrl_core;

    localparam int N         = 4;
    localparam int SB        = 6;
    localparam int BF        = 2;
    localparam int SLOT_LEN  = 1 << SB;
    localparam int FRAME_LEN = SLOT_LEN * N;
    localparam int BLINK_LEN = FRAME_LEN * BF;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  sseg;
    logic [N-1:0] an;

    sseg_mux_ctrl_core #(
        .N_DIGITS    (N),
        .SLOT_BITS   (SB),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .sseg   (sseg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registers plus t = cycles elapsed since reset release
    logic [7:0]   m_data [N];
    logic [N-1:0] m_blank;
    logic [N-1:0] m_blink;
    logic [3:0]   m_bright;
    int unsigned  t;
    int           total;
    int           bad;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a < 5'd4) begin
            for (int j = 0; j < 4; j++) begin
                int k;
                k = 4 * int'(a) + j;
                if (k < N) r[8*j +: 8] = m_data[k];
            end
        end else if (a == 5'd4) begin
            r[N-1:0]   = m_blank;
            r[16 +: N] = m_blink;
        end else if (a == 5'd5) begin
            r[3:0] = m_bright;
        end else if (a == 5'd6) begin
            r[31:16] = 16'((t / FRAME_LEN) % 65536);
            r[8]     = 1'((t / BLINK_LEN) % 2);
            r[3:0]   = 4'((t / SLOT_LEN) % N);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic [4:0] a, input logic [31:0] d);
        logic [N-1:0] ea;
        logic [7:0]   es;
        int           dig;
        bit           lit;
        reset   = rst;
        cs      = wr;
        write   = wr;
        addr    = a;
        wr_data = d;
        ea = '1;
        es = 8'hFF;
        if (!rst) begin
            dig = int'((t / SLOT_LEN) % N);
            lit = !m_blank[dig] && !(m_blink[dig] && ((t / BLINK_LEN) % 2 == 1))
                  && (int'((t % SLOT_LEN) / (SLOT_LEN / 16)) <= int'(m_bright));
            if (lit) begin
                ea[dig] = 1'b0;
                es      = m_data[dig];
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m_data[i] = 8'h00;
            m_blank  = '0;
            m_blink  = '0;
            m_bright = 4'hF;
            t        = 0;
        end else begin
            if (wr) begin
                if (a < 5'd4) begin
                    for (int j = 0; j < 4; j++) begin
                        if (4 * int'(a) + j < N) m_data[4 * int'(a) + j] = d[8*j +: 8];
                    end
                end else if (a == 5'd4) begin
                    m_blank = d[N-1:0];
                    m_blink = d[16 +: N];
                end else if (a == 5'd5) begin
                    m_bright = d[3:0];
                end
            end
            t++;
        end
        #1;
        cs    = 1'b0;
        write = 1'b0;
        chk("an", 32'(an), 32'(ea));
        chk("sseg", 32'(sseg), 32'(es));
    endtask

    task automatic rd(input logic [4:0] a);
        cs    = 1'b1;
        write = 1'b0;
        addr  = a;
        #1;
        chk($sformatf("rd_addr%0d", a), rd_data, exp_rd(a));
        cs = 1'b0;
    endtask

    initial begin
        int lit_cnt;
        int d0_cnt;
        int guard;
        total   = 0;
        bad     = 0;
        t       = 0;
        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'd0;

        // Held in reset: outputs dark, STATUS frozen at zero
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 5'd0, 32'd0);
        rd(5'd6);
        rd(5'd5);
        rd(5'd0);

        // Release and let the scan advance with default registers
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd6);

        // Four distinct digit patterns at full brightness
        step(1'b0, 1'b1, 5'd0, 32'hC0F9A4B0);
        step(1'b0, 1'b1, 5'd5, 32'd15);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd0);
        rd(5'd6);

        // Brightness 3: 16 of every 64 cycles lit, on any 256-cycle window
        step(1'b0, 1'b1, 5'd5, 32'd3);
        lit_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'd0);
            if (an != 4'hF) lit_cnt++;
        end
        chk("duty_b3", 32'(lit_cnt), 32'd64);

        // Blank digit0, blink digit1 at full brightness
        step(1'b0, 1'b1, 5'd5, 32'd15);
        step(1'b0, 1'b1, 5'd4, 32'h0002_0001);
        d0_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'd0);
            if (an[0] == 1'b0) d0_cnt++;
        end
        chk("digit0_blank", 32'(d0_cnt), 32'd0);
        rd(5'd4);
        rd(5'd6);

        // Readback of unstored bits and ignored addresses
        step(1'b0, 1'b1, 5'd1, 32'hDEADBEEF);
        rd(5'd1);
        step(1'b0, 1'b1, 5'd4, 32'hFFFF_FFFF);
        rd(5'd4);
        chk("mask_ffff", rd_data, 32'h000F_000F);
        step(1'b0, 1'b1, 5'd6, 32'h1234_5678);
        step(1'b0, 1'b1, 5'd9, 32'h8765_4321);
        rd(5'd0);
        rd(5'd4);
        rd(5'd5);
        rd(5'd6);
        step(1'b0, 1'b1, 5'd4, 32'd0);

        // Randomised writes over all addresses
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)
                step(1'b0, 1'b1, 5'($urandom_range(0, 9)), $urandom);
            else
                step(1'b0, 1'b0, 5'd0, 32'd0);
            if (i % 97 == 0) begin
                rd(5'($urandom_range(0, 9)));
                rd(5'd6);
            end
        end

        // Reset mid-slot while digit 2 is being scanned
        step(1'b0, 1'b1, 5'd0, 32'h11223344);
        guard = 0;
        while (!(((t / SLOT_LEN) % N == 2) && (t % SLOT_LEN == 20)) && guard < 2000) begin
            step(1'b0, 1'b0, 5'd0, 32'd0);
            guard++;
        end
        chk("reach_digit2", 32'((t / SLOT_LEN) % N), 32'd2);
        step(1'b1, 1'b0, 5'd0, 32'd0);
        rd(5'd6);
        rd(5'd5);
        rd(5'd0);
        rd(5'd4);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 5'd0, 32'd0);
        rd(5'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
